// File: rtl/adc_capture_hls_dl_pkg.sv
// Shared types, widths and helpers for the ADC capture HLS deadlock-detection nodes.
package adc_capture_hls_dl_pkg;

  localparam int unsigned EVT_CNT_W = 16;
  localparam int unsigned RED_MAX_W = 32;

  typedef logic [1:0] dl_state_t;

  localparam dl_state_t IDLE      = 2'd0;
  localparam dl_state_t TRACK     = 2'd1;
  localparam dl_state_t CONFIRMED = 2'd2;

  // OR-reduce of a zero-extended valid/token vector
  function automatic logic dep_or_reduce(input logic [RED_MAX_W-1:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/adc_capture_hls_dl_persist_detect_if.sv
// Dependency / token channel bundle between a dataflow process and its deadlock-detection node.
interface adc_capture_hls_dl_persist_detect_if
  import adc_capture_hls_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM     = 4,
  parameter int unsigned IN_CHAN_NUM  = 2,
  parameter int unsigned OUT_CHAN_NUM = 3
);

  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec;
  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec;
  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
  logic [IN_CHAN_NUM-1:0]          token_in_vec;
  logic                            dl_detect_in;
  logic                            origin;
  logic                            token_clear;
  logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec;
  logic [PROC_NUM-1:0]             out_chan_dep_data;
  logic [OUT_CHAN_NUM-1:0]         token_out_vec;
  logic                            dl_detect_out;
  logic [EVT_CNT_W-1:0]            dl_event_cnt;

  modport master (
    output proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
           dl_detect_in, origin, token_clear,
    input  out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out, dl_event_cnt
  );

  modport slave (
    input  proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
           dl_detect_in, origin, token_clear,
    output out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out, dl_event_cnt
  );

endinterface

// File: rtl/adc_capture_hls_dl_persist_fsm.sv
// Persistence filter: confirms a deadlock after PERSIST_CYCLES consecutive candidate cycles.
// ADC_CAPTURE_DL_CHAN_TRACE_EN exposes the confirm-entry strobe for channel tracing.
module adc_capture_hls_dl_persist_fsm
  import adc_capture_hls_dl_pkg::*;
#(
  parameter int unsigned PERSIST_CYCLES = 16,
  parameter int unsigned CNT_W          = $clog2(PERSIST_CYCLES + 1)
) (
  input  logic                 reset,
  input  logic                 clock,
  input  logic                 cand,
  input  logic                 token_clear,
  output logic                 dl_detect_out,
  output logic [EVT_CNT_W-1:0] dl_event_cnt
`ifdef ADC_CAPTURE_DL_CHAN_TRACE_EN
  ,
  output logic                 enter_c
`endif
);

  dl_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter;

`ifdef ADC_CAPTURE_DL_CHAN_TRACE_EN
  assign enter_c = enter;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dl_detect_out <= 1'b0;
      dl_event_cnt  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dl_detect_out <= (state_d == CONFIRMED);
      if (enter && (dl_event_cnt != '1)) begin
        dl_event_cnt <= dl_event_cnt + EVT_CNT_W'(1);
      end
    end
  end

  // Candidate streak tracking; a clear in CONFIRMED masks cand for that cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand) begin
          if (PERSIST_CYCLES == 1) begin
            state_d = CONFIRMED;
            cnt_d   = '0;
            enter   = 1'b1;
          end else begin
            state_d = TRACK;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      TRACK: begin
        if (!cand) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(PERSIST_CYCLES - 1)) begin
          state_d = CONFIRMED;
          cnt_d   = '0;
          enter   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONFIRMED: begin
        if (token_clear) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/adc_capture_hls_dl_persist_detect.sv
// Per-process deadlock detection node: dependency-mask propagation, token ring and persistence filter.
// ADC_CAPTURE_DL_CHAN_TRACE_EN adds dl_chan_trace, latching which input channels closed the loop.
module adc_capture_hls_dl_persist_detect
  import adc_capture_hls_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned PROC_ID        = 0,
  parameter int unsigned IN_CHAN_NUM    = 2,
  parameter int unsigned OUT_CHAN_NUM   = 3,
  parameter int unsigned PERSIST_CYCLES = 16
) (
  input  logic                            reset,
  input  logic                            clock,
  adc_capture_hls_dl_persist_detect_if.slave bus
`ifdef ADC_CAPTURE_DL_CHAN_TRACE_EN
  ,
  output logic [IN_CHAN_NUM-1:0]          dl_chan_trace
`endif
);

  localparam int unsigned         CNT_W     = $clog2(PERSIST_CYCLES + 1);
  localparam logic [PROC_NUM-1:0] SELF_MASK = PROC_NUM'(1) << PROC_ID;

  logic [PROC_NUM-1:0]  dep_comb;
  logic [PROC_NUM-1:0]  dep;
  logic [PROC_NUM-1:0]  dep_reg;
  logic                 blocked;
  logic                 tok_any;
  logic                 gate;
  logic                 cand;
  logic                 dl_det;
  logic [EVT_CNT_W-1:0] evt_cnt;

  // Merge dependency masks from every valid input channel
  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (bus.in_chan_dep_vld_vec[i]) begin
        dep_comb = dep_comb | bus.in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end
    end
  end

  assign blocked = dep_or_reduce(RED_MAX_W'(bus.proc_dep_vld_vec));
  assign tok_any = dep_or_reduce(RED_MAX_W'(bus.token_in_vec));
  // Once a global deadlock is flagged, freeze the mask unless a report token passes through
  assign gate    = ~bus.dl_detect_in | tok_any;
  assign dep     = gate ? dep_comb : dep_reg;
  assign cand    = gate & dep[PROC_ID] & blocked;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dep_reg           <= '0;
      bus.token_out_vec <= '0;
    end else begin
      dep_reg           <= blocked ? dep : '0;
      bus.token_out_vec <= ((tok_any & ~bus.token_clear) | bus.origin) ? bus.proc_dep_vld_vec : '0;
    end
  end

  assign bus.out_chan_dep_vld_vec = bus.proc_dep_vld_vec;
  assign bus.out_chan_dep_data    = dep_reg | SELF_MASK;
  assign bus.dl_detect_out        = dl_det;
  assign bus.dl_event_cnt         = evt_cnt;

`ifdef ADC_CAPTURE_DL_CHAN_TRACE_EN
  logic enter;

  adc_capture_hls_dl_persist_fsm #(
    .PERSIST_CYCLES (PERSIST_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fsm (
    .reset         (reset),
    .clock         (clock),
    .cand          (cand),
    .token_clear   (bus.token_clear),
    .dl_detect_out (dl_det),
    .dl_event_cnt  (evt_cnt),
    .enter_c       (enter)
  );

  // Snapshot of channels carrying our own ID on the confirming edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dl_chan_trace <= '0;
    end else if (enter) begin
      for (int i = 0; i < IN_CHAN_NUM; i++) begin
        dl_chan_trace[i] <= bus.in_chan_dep_vld_vec[i] & bus.in_chan_dep_data_vec[i*PROC_NUM + PROC_ID];
      end
    end else if (dl_det & bus.token_clear) begin
      dl_chan_trace <= '0;
    end
  end
`else
  adc_capture_hls_dl_persist_fsm #(
    .PERSIST_CYCLES (PERSIST_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fsm (
    .reset         (reset),
    .clock         (clock),
    .cand          (cand),
    .token_clear   (bus.token_clear),
    .dl_detect_out (dl_det),
    .dl_event_cnt  (evt_cnt)
  );
`endif

endmodule

// File: tb/tb_adc_capture_hls_dl_persist_detect.sv
// Bench for adc_capture_hls_dl_persist_detect: directed scenarios plus randomized traffic against a streak model.
module tb_adc_capture_hls_dl_persist_detect;
  import adc_capture_hls_dl_pkg::*;

  localparam int unsigned PN  = 4;
  localparam int unsigned PID = 1;
  localparam int unsigned IC  = 2;
  localparam int unsigned OC  = 3;
  localparam int unsigned PC  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmp_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  adc_capture_hls_dl_persist_detect_if #(
    .PROC_NUM(PN), .IN_CHAN_NUM(IC), .OUT_CHAN_NUM(OC)
  ) bus ();

`ifdef ADC_CAPTURE_DL_CHAN_TRACE_EN
  logic [IC-1:0] dl_chan_trace;
`endif

  adc_capture_hls_dl_persist_detect #(
    .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(IC), .OUT_CHAN_NUM(OC), .PERSIST_CYCLES(PC)
  ) dut (
    .reset (reset),
    .clock (clock),
    .bus   (bus)
`ifdef ADC_CAPTURE_DL_CHAN_TRACE_EN
    ,
    .dl_chan_trace (dl_chan_trace)
`endif
  );

  // Reference state: what the node must be reporting, from the rules alone
  logic [PN-1:0] m_dep    = '0;
  int            m_streak = 0;
  logic          m_conf   = 1'b0;
  logic [15:0]   m_evt    = '0;
  logic [OC-1:0] m_tok    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_dep    <= '0;
      m_streak <= 0;
      m_conf   <= 1'b0;
      m_evt    <= '0;
      m_tok    <= '0;
    end else begin : mdl
      logic [PN-1:0] dc;
      logic [PN-1:0] d;
      logic          g;
      logic          c;
      dc = '0;
      for (int ch = 0; ch < IC; ch++) begin
        if (bus.in_chan_dep_vld_vec[ch]) dc = dc | bus.in_chan_dep_data_vec[ch*PN +: PN];
      end
      g = !bus.dl_detect_in || (bus.token_in_vec != 0);
      d = g ? dc : m_dep;
      c = g && d[PID] && (bus.proc_dep_vld_vec != 0);
      m_dep <= (bus.proc_dep_vld_vec != 0) ? d : '0;
      if (m_conf) begin
        if (bus.token_clear) begin
          m_conf   <= 1'b0;
          m_streak <= 0;
        end
      end else if (c) begin
        if (m_streak + 1 >= int'(PC)) begin
          m_conf   <= 1'b1;
          m_streak <= 0;
          if (m_evt != 16'hFFFF) m_evt <= m_evt + 16'd1;
        end else begin
          m_streak <= m_streak + 1;
        end
      end else begin
        m_streak <= 0;
      end
      m_tok <= (((bus.token_in_vec != 0) && !bus.token_clear) || bus.origin) ? bus.proc_dep_vld_vec : '0;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cmp_dl_detect", 32'(bus.dl_detect_out), 32'(m_conf));
      check("cmp_event_cnt", 32'(bus.dl_event_cnt), 32'(m_evt));
      check("cmp_token_out", 32'(bus.token_out_vec), 32'(m_tok));
      check("cmp_dep_data", 32'(bus.out_chan_dep_data), 32'(m_dep | 4'b0010));
      check("cmp_dep_vld", 32'(bus.out_chan_dep_vld_vec), 32'(bus.proc_dep_vld_vec));
    end
  end

  task automatic cyc(input logic [2:0] pdv, input logic [1:0] iv, input logic [7:0] id,
                     input logic [1:0] ti, input logic dli, input logic org, input logic clr);
    bus.proc_dep_vld_vec     = pdv;
    bus.in_chan_dep_vld_vec  = iv;
    bus.in_chan_dep_data_vec = id;
    bus.token_in_vec         = ti;
    bus.dl_detect_in         = dli;
    bus.origin               = org;
    bus.token_clear          = clr;
    @(posedge clock);
    #2;
  endtask

  task automatic cand_cyc();
    cyc(3'b001, 2'b01, 8'h02, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cyc(input logic clr);
    cyc(3'b000, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, clr);
  endtask

  initial begin
    bus.proc_dep_vld_vec     = '0;
    bus.in_chan_dep_vld_vec  = '0;
    bus.in_chan_dep_data_vec = '0;
    bus.token_in_vec         = '0;
    bus.dl_detect_in         = 1'b0;
    bus.origin               = 1'b0;
    bus.token_clear          = 1'b0;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    check("reset_dl", 32'(bus.dl_detect_out), 32'd0);
    check("reset_evt", 32'(bus.dl_event_cnt), 32'd0);
    check("reset_tok", 32'(bus.token_out_vec), 32'd0);
    check("reset_data", 32'(bus.out_chan_dep_data), 32'h2);

    // persistent loop: confirmed right after the 4th candidate edge
    repeat (3) cand_cyc();
    check("persist_early", 32'(bus.dl_detect_out), 32'd0);
    cand_cyc();
    check("persist_dl", 32'(bus.dl_detect_out), 32'd1);
    check("persist_evt", 32'(bus.dl_event_cnt), 32'd1);

    // clear with candidate still high, then re-arm
    cyc(3'b001, 2'b01, 8'h02, 2'b00, 1'b0, 1'b0, 1'b1);
    check("clear_dl", 32'(bus.dl_detect_out), 32'd0);
    repeat (3) cand_cyc();
    check("rearm_early", 32'(bus.dl_detect_out), 32'd0);
    cand_cyc();
    check("rearm_dl", 32'(bus.dl_detect_out), 32'd1);
    check("rearm_evt", 32'(bus.dl_event_cnt), 32'd2);
    idle_cyc(1'b1);
    check("clear2_dl", 32'(bus.dl_detect_out), 32'd0);

    // transient: one non-candidate cycle breaks the streak
    repeat (3) cand_cyc();
    cyc(3'b001, 2'b01, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("transient_gap", 32'(bus.dl_detect_out), 32'd0);
    repeat (3) cand_cyc();
    check("transient_dl", 32'(bus.dl_detect_out), 32'd0);
    check("transient_evt", 32'(bus.dl_event_cnt), 32'd2);
    idle_cyc(1'b0);

    // gating: global flag freezes the mask until a token arrives
    cyc(3'b001, 2'b10, 8'h80, 2'b00, 1'b0, 1'b0, 1'b0);
    check("gate_seed", 32'(bus.out_chan_dep_data), 32'hA);
    repeat (4) cyc(3'b001, 2'b01, 8'h02, 2'b00, 1'b1, 1'b0, 1'b0);
    check("gate_hold", 32'(bus.out_chan_dep_data), 32'hA);
    check("gate_nocand", 32'(bus.dl_detect_out), 32'd0);
    cyc(3'b001, 2'b01, 8'h02, 2'b10, 1'b1, 1'b0, 1'b0);
    check("gate_track", 32'(bus.out_chan_dep_data), 32'h2);
    check("gate_tok", 32'(bus.token_out_vec), 32'h1);
    idle_cyc(1'b0);

    // tokens
    cyc(3'b101, 2'b00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("tok_origin", 32'(bus.token_out_vec), 32'h5);
    cyc(3'b101, 2'b00, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1);
    check("tok_clear", 32'(bus.token_out_vec), 32'h0);
    check("tok_vld", 32'(bus.out_chan_dep_vld_vec), 32'h5);

    // reset in the middle of a streak
    repeat (2) cand_cyc();
    reset = 1'b0;
    #1;
    check("rst_dl", 32'(bus.dl_detect_out), 32'd0);
    check("rst_evt", 32'(bus.dl_event_cnt), 32'd0);
    check("rst_tok", 32'(bus.token_out_vec), 32'd0);
    check("rst_data", 32'(bus.out_chan_dep_data), 32'h2);
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (3) cand_cyc();
    check("post_rst_early", 32'(bus.dl_detect_out), 32'd0);
    cand_cyc();
    check("post_rst_dl", 32'(bus.dl_detect_out), 32'd1);
    check("post_rst_evt", 32'(bus.dl_event_cnt), 32'd1);
    idle_cyc(1'b1);

    // randomized traffic, biased towards closed dependency loops
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
      end else begin
        logic [2:0] pdv;
        logic [1:0] iv;
        logic [7:0] id;
        pdv = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        iv  = ($urandom_range(0, 3) != 0) ? (2'b01 | 2'($urandom)) : 2'($urandom);
        id  = 8'($urandom) | (($urandom_range(0, 7) != 0) ? 8'h22 : 8'h00);
        cyc(pdv, iv, id, 2'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      end
    end

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
